sd_wb_master_arb: RTL and testbench
===================================

SD_WB_MASTER_ARB -- requirements
Module: sd_wb_master_arb

Interface
REQ-001 Parameter TO_CYCLES, default 255, meaning ack timeout in clk cycles (1..65535); used only when SD_WB_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system/Wishbone clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tx_adr_i, tx_dat_i, tx_we_i, tx_cyc_i, tx_stb_i, tx_cti_i, tx_bte_i  input  32/32/1/1/1/3/2  requester 0 (TX fifo filler) Wishbone master-side signals.
REQ-005 tx_dat_o  output  32  read data to requester 0; tx_ack_o  output  1  ack to requester 0.
REQ-006 rx_adr_i, rx_dat_i, rx_we_i, rx_cyc_i, rx_stb_i, rx_cti_i, rx_bte_i  input  32/32/1/1/1/3/2  requester 1 (RX fifo filler) signals.
REQ-007 rx_dat_o  output  32; rx_ack_o  output  1  read data and ack to requester 1.
REQ-008 m_wb_adr_o 32, m_wb_dat_o 32, m_wb_we_o 1, m_wb_cyc_o 1, m_wb_stb_o 1, m_wb_cti_o 3, m_wb_bte_o 2  output  shared Wishbone master port.
REQ-009 m_wb_dat_i  input  32; m_wb_ack_i  input  1  shared port return path.
REQ-010 gnt_o  output  2  one-hot current owner (bit0 TX, bit1 RX), 2'b00 when idle.
REQ-011 to_err_o  output  1  sticky timeout flag; to_clr_i  input  1  clears to_err_o.

Function
REQ-012 FSM states SHALL be IDLE, GNT_TX, GNT_RX, DRAIN; gnt_o decoded from state.
REQ-013 In IDLE, a requester is requesting when its cyc_i&stb_i=1; SM SHALL move to that requester's GNT state on the next edge (one-cycle arbitration latency).
REQ-014 Both requesting in IDLE: grant the one NOT granted last (round-robin pointer last_rx, reset 0, so TX wins the first tie).
REQ-015 In GNT_x, m_wb_* outputs SHALL combinationally mirror requester x; otherwise adr/dat/cti/bte=0, we/cyc/stb=0.
REQ-016 m_wb_ack_i and m_wb_dat_i SHALL route only to the owner; non-owner ack=0 always; dat_o of both SHALL carry m_wb_dat_i (data only qualified by ack).
REQ-017 Owner's cyc_i low in GNT_x: SM SHALL go to IDLE next edge, update last_rx; no re-grant in the same cycle (one dead cycle between owners).
REQ-018 Owner holding cyc across several acks (burst, cti=3'b010) SHALL keep the grant; no preemption.
REQ-019 Ack arriving while idle or during DRAIN SHALL be discarded.
REQ-020 Requester dropping cyc before being granted SHALL lose its request with no side effect.

Reset
REQ-021 rst=1 SHALL force IDLE, last_rx=0, timeout counter=0, to_err_o=0, gnt_o=0, all m_wb_* outputs 0, tx/rx_ack_o=0, regardless of clk.
REQ-022 rst asserted mid-transfer SHALL drop m_wb_cyc_o/stb_o in the same cycle (combinational from state).

Configuration
REQ-023 Macro SD_WB_ARB_TIMEOUT_EN defined: 16-bit counter increments each GNT cycle with m_wb_stb_o=1 and m_wb_ack_i=0, clears on ack or leaving GNT; on reaching TO_CYCLES SM SHALL enter DRAIN, set to_err_o, deassert cyc/stb.
REQ-024 DRAIN: owner signals ignored, SM returns to IDLE when that owner's cyc_i is low; last_rx updated as for normal release.
REQ-025 to_clr_i SHALL clear to_err_o next edge; simultaneous new timeout takes priority (flag stays 1).
REQ-026 Macro undefined: no counter, DRAIN unreachable, to_err_o tied 0, to_clr_i ignored.

Structure
REQ-027 Shared package sd_wb_arb_pkg SHALL hold the state enum, requester index constants (REQ_TX=0, REQ_RX=1), CTI constants (classic 3'b000, incr 3'b010, end 3'b111).
REQ-028 Single module, no sub-modules; timeout counter inline under the macro.

Verification
REQ-029 TX only: tx cyc/stb, adr=0x1000, ack after 3 cycles -> gnt_o=01 one cycle later, m_wb_adr_o=0x1000, tx_ack_o=1 with tx_dat_o=m_wb_dat_i, rx_ack_o=0.
REQ-030 Tie from reset: both request same cycle -> TX granted first, after TX release plus one dead cycle RX granted; next tie -> TX.
REQ-031 RX burst of 4 acks with cyc held -> gnt_o stays 10 all four, TX request pending throughout waits, then gets grant.
REQ-032 Timeout (macro on, TO_CYCLES=8): TX requests, no ack -> cyc drops after 8 stalled cycles, to_err_o=1, DRAIN until tx_cyc_i low; to_clr_i pulse -> to_err_o=0.
REQ-033 Async rst pulse mid RX transfer -> m_wb_cyc_o=0 immediately, gnt_o=00, to_err_o=0, next tie grants TX.

Source files
------------

// File: rtl/sd_wb_arb_pkg.sv
// Shared definitions for the SD controller Wishbone master arbiter:
// FSM state encoding, requester indices and Wishbone CTI codes.
package sd_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_TX = 2'd1,
        GNT_RX = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    localparam int unsigned REQ_TX = 0;
    localparam int unsigned REQ_RX = 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/sd_wb_master_arb.sv
// Two-requester (TX/RX fifo filler) round-robin arbiter onto one Wishbone master port.
// Define SD_WB_ARB_TIMEOUT_EN to enable the ack timeout and DRAIN recovery path.
module sd_wb_master_arb
    import sd_wb_arb_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] tx_adr_i,
    input  logic [31:0] tx_dat_i,
    input  logic        tx_we_i,
    input  logic        tx_cyc_i,
    input  logic        tx_stb_i,
    input  logic [2:0]  tx_cti_i,
    input  logic [1:0]  tx_bte_i,
    output logic [31:0] tx_dat_o,
    output logic        tx_ack_o,

    input  logic [31:0] rx_adr_i,
    input  logic [31:0] rx_dat_i,
    input  logic        rx_we_i,
    input  logic        rx_cyc_i,
    input  logic        rx_stb_i,
    input  logic [2:0]  rx_cti_i,
    input  logic [1:0]  rx_bte_i,
    output logic [31:0] rx_dat_o,
    output logic        rx_ack_o,

    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,

    output logic [1:0]  gnt_o,
    output logic        to_err_o,
    input  logic        to_clr_i
);

    arb_state_t state_q, state_d;
    logic       last_rx_q, last_rx_d;
    logic       served_q, served_d;
    logic       tx_req, rx_req;
    logic       stalled;
    logic       timeout;
    logic       drain_rx;

    assign tx_req  = tx_cyc_i & tx_stb_i;
    assign rx_req  = rx_cyc_i & rx_stb_i;
    assign stalled = m_wb_stb_o & ~m_wb_ack_i;

`ifdef SD_WB_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        drain_rx_q;
    logic        to_err_q;
    logic        owner_cyc;

    assign owner_cyc = ((state_q == GNT_TX) & tx_cyc_i) | ((state_q == GNT_RX) & rx_cyc_i);
    assign timeout   = owner_cyc & stalled & (to_cnt_q == 16'(TO_CYCLES - 1));
    assign drain_rx  = drain_rx_q;
    assign to_err_o  = to_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q   <= '0;
            drain_rx_q <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            if ((state_q == GNT_TX || state_q == GNT_RX) && state_d == state_q) begin
                if (m_wb_ack_i)
                    to_cnt_q <= '0;
                else if (stalled)
                    to_cnt_q <= to_cnt_q + 16'd1;
            end else begin
                to_cnt_q <= '0;
            end
            if (timeout)
                drain_rx_q <= (state_q == GNT_RX);
            // A fresh timeout wins over a clear request in the same cycle.
            if (timeout)
                to_err_q <= 1'b1;
            else if (to_clr_i)
                to_err_q <= 1'b0;
        end
    end
`else
    logic unused;
    assign unused   = ^{to_clr_i, 16'(TO_CYCLES)};
    assign timeout  = 1'b0;
    assign drain_rx = 1'b0;
    assign to_err_o = 1'b0;
`endif

    // last_rx alone cannot express "nobody served yet", so served_q lets TX
    // win the first tie after reset while later ties alternate.
    always_comb begin
        state_d   = state_q;
        last_rx_d = last_rx_q;
        served_d  = served_q;
        case (state_q)
            IDLE: begin
                if (tx_req && rx_req)
                    state_d = (served_q && !last_rx_q) ? GNT_RX : GNT_TX;
                else if (tx_req)
                    state_d = GNT_TX;
                else if (rx_req)
                    state_d = GNT_RX;
            end
            GNT_TX: begin
                if (!tx_cyc_i) begin
                    state_d   = IDLE;
                    last_rx_d = 1'b0;
                    served_d  = 1'b1;
                end else if (timeout) begin
                    state_d = DRAIN;
                end
            end
            GNT_RX: begin
                if (!rx_cyc_i) begin
                    state_d   = IDLE;
                    last_rx_d = 1'b1;
                    served_d  = 1'b1;
                end else if (timeout) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!(drain_rx ? rx_cyc_i : tx_cyc_i)) begin
                    state_d   = IDLE;
                    last_rx_d = drain_rx;
                    served_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_rx_q <= 1'b0;
            served_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rx_q <= last_rx_d;
            served_q  <= served_d;
        end
    end

    always_comb begin
        m_wb_adr_o = '0;
        m_wb_dat_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_cyc_o = 1'b0;
        m_wb_stb_o = 1'b0;
        m_wb_cti_o = '0;
        m_wb_bte_o = '0;
        if (state_q == GNT_TX) begin
            m_wb_adr_o = tx_adr_i;
            m_wb_dat_o = tx_dat_i;
            m_wb_we_o  = tx_we_i;
            m_wb_cyc_o = tx_cyc_i;
            m_wb_stb_o = tx_stb_i;
            m_wb_cti_o = tx_cti_i;
            m_wb_bte_o = tx_bte_i;
        end else if (state_q == GNT_RX) begin
            m_wb_adr_o = rx_adr_i;
            m_wb_dat_o = rx_dat_i;
            m_wb_we_o  = rx_we_i;
            m_wb_cyc_o = rx_cyc_i;
            m_wb_stb_o = rx_stb_i;
            m_wb_cti_o = rx_cti_i;
            m_wb_bte_o = rx_bte_i;
        end
    end

    always_comb begin
        gnt_o         = '0;
        gnt_o[REQ_TX] = (state_q == GNT_TX);
        gnt_o[REQ_RX] = (state_q == GNT_RX);
    end

    assign tx_ack_o = (state_q == GNT_TX) & m_wb_ack_i;
    assign rx_ack_o = (state_q == GNT_RX) & m_wb_ack_i;
    assign tx_dat_o = m_wb_dat_i;
    assign rx_dat_o = m_wb_dat_i;

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// Directed self-checking bench for sd_wb_master_arb; covers the timeout
// path when SD_WB_ARB_TIMEOUT_EN is defined, otherwise checks it stays inert.
module tb_sd_wb_master_arb;
    import sd_wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_adr_i, tx_dat_i, rx_adr_i, rx_dat_i;
    logic        tx_we_i, tx_cyc_i, tx_stb_i, rx_we_i, rx_cyc_i, rx_stb_i;
    logic [2:0]  tx_cti_i, rx_cti_i;
    logic [1:0]  tx_bte_i, rx_bte_i;
    logic [31:0] tx_dat_o, rx_dat_o;
    logic        tx_ack_o, rx_ack_o;
    logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_ack_i;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic [1:0]  gnt_o;
    logic        to_err_o, to_clr_i;

    int checks = 0;
    int errors = 0;

    sd_wb_master_arb #(.TO_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .tx_adr_i(tx_adr_i), .tx_dat_i(tx_dat_i), .tx_we_i(tx_we_i), .tx_cyc_i(tx_cyc_i),
        .tx_stb_i(tx_stb_i), .tx_cti_i(tx_cti_i), .tx_bte_i(tx_bte_i),
        .tx_dat_o(tx_dat_o), .tx_ack_o(tx_ack_o),
        .rx_adr_i(rx_adr_i), .rx_dat_i(rx_dat_i), .rx_we_i(rx_we_i), .rx_cyc_i(rx_cyc_i),
        .rx_stb_i(rx_stb_i), .rx_cti_i(rx_cti_i), .rx_bte_i(rx_bte_i),
        .rx_dat_o(rx_dat_o), .rx_ack_o(rx_ack_o),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cti_o(m_wb_cti_o),
        .m_wb_bte_o(m_wb_bte_o), .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i),
        .gnt_o(gnt_o), .to_err_o(to_err_o), .to_clr_i(to_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        tx_adr_i = '0; tx_dat_i = '0; tx_we_i = 1'b0; tx_cyc_i = 1'b0; tx_stb_i = 1'b0;
        tx_cti_i = CTI_CLASSIC; tx_bte_i = '0;
        rx_adr_i = '0; rx_dat_i = '0; rx_we_i = 1'b0; rx_cyc_i = 1'b0; rx_stb_i = 1'b0;
        rx_cti_i = CTI_CLASSIC; rx_bte_i = '0;
        m_wb_dat_i = '0; m_wb_ack_i = 1'b0; to_clr_i = 1'b0;
        #12;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_cyc", 32'(m_wb_cyc_o), 32'd0);
        chk("rst_to_err", 32'(to_err_o), 32'd0);
        chk("rst_ack", 32'({tx_ack_o, rx_ack_o}), 32'd0);
        tick();
        rst = 1'b0;

        // TX-only single transfer
        tick();
        tx_adr_i = 32'h0000_1000; tx_dat_i = 32'h1111_2222; tx_we_i = 1'b1;
        tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
        #1;
        chk("tx_latency_gnt", 32'(gnt_o), 32'd0);
        chk("tx_latency_cyc", 32'(m_wb_cyc_o), 32'd0);
        tick();
        chk("tx_gnt", 32'(gnt_o), 32'd1);
        chk("tx_adr", m_wb_adr_o, 32'h0000_1000);
        chk("tx_cyc", 32'(m_wb_cyc_o), 32'd1);
        chk("tx_we", 32'(m_wb_we_o), 32'd1);
        chk("tx_dat_out", m_wb_dat_o, 32'h1111_2222);
        tick();
        tick();
        chk("tx_ack_wait", 32'(tx_ack_o), 32'd0);
        m_wb_ack_i = 1'b1; m_wb_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("tx_ack", 32'(tx_ack_o), 32'd1);
        chk("tx_rdat", tx_dat_o, 32'hDEAD_BEEF);
        chk("tx_rx_ack_quiet", 32'(rx_ack_o), 32'd0);
        chk("tx_rx_dat_bcast", rx_dat_o, 32'hDEAD_BEEF);
        tick();
        m_wb_ack_i = 1'b0; tx_cyc_i = 1'b0; tx_stb_i = 1'b0;
        #1;
        chk("tx_release_cyc_comb", 32'(m_wb_cyc_o), 32'd0);
        tick();
        chk("tx_release_gnt", 32'(gnt_o), 32'd0);
        m_wb_ack_i = 1'b1;
        #1;
        chk("idle_ack_dropped", 32'({tx_ack_o, rx_ack_o}), 32'd0);
        m_wb_ack_i = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;

        // Tie from reset, then alternation
        tick();
        tx_adr_i = 32'h0000_2000; tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
        rx_adr_i = 32'h0000_3000; rx_cyc_i = 1'b1; rx_stb_i = 1'b1;
        tick();
        chk("tie1_gnt_tx", 32'(gnt_o), 32'd1);
        chk("tie1_adr", m_wb_adr_o, 32'h0000_2000);
        tx_cyc_i = 1'b0; tx_stb_i = 1'b0;
        tick();
        chk("tie1_dead_cycle", 32'(gnt_o), 32'd0);
        tick();
        chk("tie1_gnt_rx", 32'(gnt_o), 32'd2);
        chk("tie1_rx_adr", m_wb_adr_o, 32'h0000_3000);
        rx_cyc_i = 1'b0; rx_stb_i = 1'b0;
        tick();
        chk("rx_release_gnt", 32'(gnt_o), 32'd0);
        tx_cyc_i = 1'b1; tx_stb_i = 1'b1; rx_cyc_i = 1'b1; rx_stb_i = 1'b1;
        tick();
        chk("tie2_gnt_tx", 32'(gnt_o), 32'd1);
        rx_cyc_i = 1'b0; rx_stb_i = 1'b0;
        tx_cyc_i = 1'b0; tx_stb_i = 1'b0;
        tick();
        tick();
        chk("rx_withdrawn", 32'(gnt_o), 32'd0);

        // RX burst with TX pending
        rx_adr_i = 32'h0000_4000; rx_cti_i = CTI_INCR; rx_cyc_i = 1'b1; rx_stb_i = 1'b1;
        tick();
        chk("burst_gnt", 32'(gnt_o), 32'd2);
        tx_adr_i = 32'h0000_5000; tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_cti_i = (i == 3) ? CTI_END : CTI_INCR;
            m_wb_ack_i = 1'b1;
            #1;
            chk("burst_hold_gnt", 32'(gnt_o), 32'd2);
            chk("burst_rx_ack", 32'(rx_ack_o), 32'd1);
            chk("burst_tx_ack", 32'(tx_ack_o), 32'd0);
            chk("burst_cti", 32'(m_wb_cti_o), (i == 3) ? 32'd7 : 32'd2);
            tick();
        end
        m_wb_ack_i = 1'b0; rx_cyc_i = 1'b0; rx_stb_i = 1'b0; rx_cti_i = CTI_CLASSIC;
        tick();
        chk("burst_dead_cycle", 32'(gnt_o), 32'd0);
        tick();
        chk("pending_tx_gnt", 32'(gnt_o), 32'd1);
        chk("pending_tx_adr", m_wb_adr_o, 32'h0000_5000);

        // TX now owns the bus and never sees an ack
`ifdef SD_WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("stall_cyc_held", 32'(m_wb_cyc_o), 32'd1);
        end
        tick();
        chk("to_cyc_drop", 32'(m_wb_cyc_o), 32'd0);
        chk("to_stb_drop", 32'(m_wb_stb_o), 32'd0);
        chk("to_gnt", 32'(gnt_o), 32'd0);
        chk("to_err_set", 32'(to_err_o), 32'd1);
        m_wb_ack_i = 1'b1;
        #1;
        chk("drain_ack_dropped", 32'(tx_ack_o), 32'd0);
        m_wb_ack_i = 1'b0;
        tick();
        chk("drain_err_sticky", 32'(to_err_o), 32'd1);
        tx_cyc_i = 1'b0; tx_stb_i = 1'b0;
        tick();
        to_clr_i = 1'b1;
        tick();
        to_clr_i = 1'b0;
        chk("to_err_cleared", 32'(to_err_o), 32'd0);
`else
        to_clr_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("stall_no_timeout", 32'(m_wb_cyc_o), 32'd1);
        end
        to_clr_i = 1'b0;
        chk("stall_gnt", 32'(gnt_o), 32'd1);
        chk("to_err_tied", 32'(to_err_o), 32'd0);
        tx_cyc_i = 1'b0; tx_stb_i = 1'b0;
        tick();
        chk("stall_release", 32'(gnt_o), 32'd0);
`endif

        // RX transfer interrupted by async reset
        rx_adr_i = 32'h0000_6000; rx_cyc_i = 1'b1; rx_stb_i = 1'b1;
        tick();
        chk("pre_rst_gnt", 32'(gnt_o), 32'd2);
        chk("pre_rst_cyc", 32'(m_wb_cyc_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cyc", 32'(m_wb_cyc_o), 32'd0);
        chk("async_rst_stb", 32'(m_wb_stb_o), 32'd0);
        chk("async_rst_gnt", 32'(gnt_o), 32'd0);
        chk("async_rst_to_err", 32'(to_err_o), 32'd0);
        tx_adr_i = 32'h0000_7000; tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_tie_tx", 32'(gnt_o), 32'd1);
        chk("post_rst_adr", m_wb_adr_o, 32'h0000_7000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
